nios2_debug_scan_master: RTL and testbench

- Host-side initiator for the Nios II debug slave's virtual-JTAG interface.
- Accepts one command per transaction, made of a 2-bit IR and a 38-bit DR word.
- Generates tck/tdi, ir_in and the virtual-state strobes (uir, cdr, sdr, udr, rti) in the system clock domain, and returns the 38-bit word shifted out on tdo.
- Used by the fpga-writer control path and as the stimulus engine for debug-slave benches.

---
 rtl/nios2_debug_scan_master.sv | 217 +++++++++++++++++++++
 tb/tb_nios2_debug_scan_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_scan_master.sv
// nios2_debug_scan_master
// Host-side initiator for the Nios II debug slave's virtual-JTAG interface.
// Each accepted command (IR + DR word) is played out as the virtual state
// sequence UIR -> CDR -> SDR -> UDR -> RTI. Every phase step is one tck period:
// low half first, then high half. The word shifted out on tdo is returned as
// the response.
//
// Optional feature: define NIOS2_SCAN_IR_SKIP_EN to skip the UIR phase when
// the command's IR equals the IR already loaded into the slave.
//
// Ports:
//   clk, reset_n         system clock, synchronous active-low reset
//   cmd_valid/ready      command handshake; cmd_ir, cmd_dr carry the command
//   rsp_valid/ready      response handshake; rsp_dr is the captured tdo word,
//                        rsp_ir_out is the ir_out value sampled in UIR
//   tck, tdi, tdo        generated test clock and serial data
//   ir_in, ir_out        virtual IR and its readback
//   vs_uir/cdr/sdr/udr   virtual state strobes
//   jtag_state_rti       run-test-idle strobe
//   busy                 high whenever the master is not idle
module nios2_debug_scan_master #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                tck,
   output logic                tdi,
   input  logic                tdo,
   output logic [IR_WIDTH-1:0] ir_in,
   input  logic [IR_WIDTH-1:0] ir_out,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_udr,
   output logic                jtag_state_rti,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RSP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);
   localparam logic [5:0] BIT_LAST = 6'(DR_WIDTH - 1);

   state_t              state;
   logic [7:0]          div_cnt;
   logic [5:0]          bit_cnt;
   logic [DR_WIDTH-1:0] tx_sr;
   logic [DR_WIDTH-1:0] rx_sr;
   logic [DR_WIDTH-1:0] tx_next;
   logic                in_phase;
   logic                half_done;
   logic                tck_rise;
   logic                tck_fall;
   logic                accept;
   logic                skip_uir;

   // tck only runs while a virtual-state phase is active
   assign in_phase  = (state != S_IDLE) && (state != S_RSP);
   assign half_done = (div_cnt == DIV_LAST);
   assign tck_rise  = in_phase && half_done && !tck;
   // a falling tck is the period boundary where phases and tdi advance
   assign tck_fall  = in_phase && half_done && tck;
   assign accept    = cmd_valid && cmd_ready;
   assign tx_next   = tx_sr >> 1;

`ifdef NIOS2_SCAN_IR_SKIP_EN
   // ir_valid: ir_in matches what the slave actually latched through a UIR
   logic ir_valid;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ir_valid <= 1'b0;
      end else if (accept && !skip_uir) begin
         ir_valid <= 1'b0;
      end else if ((state == S_UIR) && tck_fall) begin
         ir_valid <= 1'b1;
      end
   end

   assign skip_uir = ir_valid && (cmd_ir == ir_in);
`else
   assign skip_uir = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         div_cnt        <= 8'd0;
         bit_cnt        <= 6'd0;
         tx_sr          <= '0;
         rx_sr          <= '0;
         cmd_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_dr         <= '0;
         rsp_ir_out     <= '0;
         tck            <= 1'b0;
         tdi            <= 1'b0;
         ir_in          <= '0;
         vs_uir         <= 1'b0;
         vs_cdr         <= 1'b0;
         vs_sdr         <= 1'b0;
         vs_udr         <= 1'b0;
         jtag_state_rti <= 1'b0;
         busy           <= 1'b0;
      end else begin
         // divider reloads explicitly at the end of each half-period
         if (in_phase) begin
            div_cnt <= half_done ? 8'd0 : div_cnt + 8'd1;
         end

         if (tck_rise) begin
            tck <= 1'b1;
            if (state == S_UIR) begin
               rsp_ir_out <= ir_out;
            end
            if (state == S_SDR) begin
               rx_sr <= {tdo, rx_sr[DR_WIDTH-1:1]};
            end
         end

         if (tck_fall) begin
            tck <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (accept) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  ir_in     <= cmd_ir;
                  tx_sr     <= cmd_dr;
                  rx_sr     <= '0;
                  div_cnt   <= 8'd0;
                  if (skip_uir) begin
                     state  <= S_CDR;
                     vs_cdr <= 1'b1;
                  end else begin
                     state  <= S_UIR;
                     vs_uir <= 1'b1;
                  end
               end
            end
            S_UIR: begin
               if (tck_fall) begin
                  state  <= S_CDR;
                  vs_uir <= 1'b0;
                  vs_cdr <= 1'b1;
               end
            end
            S_CDR: begin
               if (tck_fall) begin
                  state   <= S_SDR;
                  vs_cdr  <= 1'b0;
                  vs_sdr  <= 1'b1;
                  bit_cnt <= 6'd0;
                  tdi     <= tx_sr[0];
               end
            end
            S_SDR: begin
               if (tck_fall) begin
                  if (bit_cnt == BIT_LAST) begin
                     state  <= S_UDR;
                     vs_sdr <= 1'b0;
                     vs_udr <= 1'b1;
                     tdi    <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                     tx_sr   <= tx_next;
                     tdi     <= tx_next[0];
                  end
               end
            end
            S_UDR: begin
               if (tck_fall) begin
                  state          <= S_RTI;
                  vs_udr         <= 1'b0;
                  jtag_state_rti <= 1'b1;
               end
            end
            S_RTI: begin
               if (tck_fall) begin
                  state          <= S_RSP;
                  jtag_state_rti <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_dr         <= rx_sr;
               end
            end
            S_RSP: begin
               // response held until consumed; a new command waits for IDLE
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Bench for nios2_debug_scan_master: instance 0 uses TCK_DIV=2, instance 1
// uses TCK_DIV=1. Each instance talks to a loopback slave model that preloads
// its shift register on CDR, shifts on tck during SDR and captures at UDR.
module tb_nios2_debug_scan_master;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic [1:0]       cmd_valid = '0;
   logic [1:0]       cmd_ready;
   logic [1:0][1:0]  cmd_ir = '0;
   logic [1:0][37:0] cmd_dr = '0;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready = '0;
   logic [1:0][37:0] rsp_dr;
   logic [1:0][1:0]  rsp_ir_out;
   logic [1:0]       tck;
   logic [1:0]       tdi;
   logic [1:0]       tdo;
   logic [1:0][1:0]  ir_in;
   logic [1:0][1:0]  ir_out = '0;
   logic [1:0]       vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   nios2_debug_scan_master #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(2)) u_dut0 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_ir(cmd_ir[0]), .cmd_dr(cmd_dr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_dr(rsp_dr[0]), .rsp_ir_out(rsp_ir_out[0]),
      .tck(tck[0]), .tdi(tdi[0]), .tdo(tdo[0]),
      .ir_in(ir_in[0]), .ir_out(ir_out[0]),
      .vs_uir(vs_uir[0]), .vs_cdr(vs_cdr[0]), .vs_sdr(vs_sdr[0]), .vs_udr(vs_udr[0]),
      .jtag_state_rti(jtag_state_rti[0]), .busy(busy[0])
   );

   nios2_debug_scan_master #(.DR_WIDTH(38), .IR_WIDTH(2), .TCK_DIV(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_ir(cmd_ir[1]), .cmd_dr(cmd_dr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_dr(rsp_dr[1]), .rsp_ir_out(rsp_ir_out[1]),
      .tck(tck[1]), .tdi(tdi[1]), .tdo(tdo[1]),
      .ir_in(ir_in[1]), .ir_out(ir_out[1]),
      .vs_uir(vs_uir[1]), .vs_cdr(vs_cdr[1]), .vs_sdr(vs_sdr[1]), .vs_udr(vs_udr[1]),
      .jtag_state_rti(jtag_state_rti[1]), .busy(busy[1])
   );

   // loopback slave models
   logic [1:0][37:0] preload = '0;
   logic [37:0] sr0 = '0, sr1 = '0, cap0 = '0, cap1 = '0;

   always @(posedge tck[0]) begin
      if (vs_cdr[0])      sr0 <= preload[0];
      else if (vs_sdr[0]) sr0 <= {tdi[0], sr0[37:1]};
      else if (vs_udr[0]) cap0 <= sr0;
   end

   always @(posedge tck[1]) begin
      if (vs_cdr[1])      sr1 <= preload[1];
      else if (vs_sdr[1]) sr1 <= {tdi[1], sr1[37:1]};
      else if (vs_udr[1]) cap1 <= sr1;
   end

   assign tdo = {sr1[0], sr0[0]};

   // cumulative activity monitor, sampled away from the active edge
   // strobe bit order: 4=uir 3=cdr 2=sdr 1=udr 0=rti
   int rise_cnt [2][5];
   int cyc_cnt  [2][5];
   int tckr_cnt [2];
   int tdih_cnt [2];
   int viol_cnt [2];
   int rspr_cnt [2];
   logic [1:0][4:0] prev_st = '0;
   logic [1:0]      prev_tck = '0;
   logic [1:0]      prev_rsp = '0;

   initial begin
      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 5; k++) begin
            rise_cnt[u][k] = 0;
            cyc_cnt[u][k]  = 0;
         end
         tckr_cnt[u] = 0; tdih_cnt[u] = 0; viol_cnt[u] = 0; rspr_cnt[u] = 0;
      end
   end

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         logic [4:0] st;
         st = {vs_uir[u], vs_cdr[u], vs_sdr[u], vs_udr[u], jtag_state_rti[u]};
         for (int k = 0; k < 5; k++) begin
            if (st[k] === 1'b1) cyc_cnt[u][k] = cyc_cnt[u][k] + 1;
            if (st[k] === 1'b1 && prev_st[u][k] !== 1'b1) rise_cnt[u][k] = rise_cnt[u][k] + 1;
         end
         if (tck[u] === 1'b1 && prev_tck[u] !== 1'b1) tckr_cnt[u] = tckr_cnt[u] + 1;
         if (tdi[u] === 1'b1) tdih_cnt[u] = tdih_cnt[u] + 1;
         if (rsp_valid[u] === 1'b1 && prev_rsp[u] !== 1'b1) rspr_cnt[u] = rspr_cnt[u] + 1;
         if ($countones(st) > 1) viol_cnt[u] = viol_cnt[u] + 1;
         if (tdi[u] === 1'b1 && vs_sdr[u] !== 1'b1) viol_cnt[u] = viol_cnt[u] + 1;
         if (tck[u] === 1'b1 && (rsp_valid[u] === 1'b1 || busy[u] === 1'b0)) viol_cnt[u] = viol_cnt[u] + 1;
         if (cmd_ready[u] === 1'b1 && busy[u] === 1'b1) viol_cnt[u] = viol_cnt[u] + 1;
         prev_st[u]  = st;
         prev_tck[u] = tck[u];
         prev_rsp[u] = rsp_valid[u];
      end
   end

   // reference state per instance
   logic [1:0]      ir_loaded = '0;
   logic [1:0][1:0] ir_model  = '0;
   logic [1:0][1:0] irout_exp = '0;

   // snapshots of monitor counters at transaction start
   int rise_s [5];
   int cyc_s  [5];
   int tckr_s, tdih_s, viol_s, rspr_s;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] outs(input int u);
      return {12'd0, cmd_ready[u], rsp_valid[u], rsp_dr[u], rsp_ir_out[u], tck[u], tdi[u],
              ir_in[u], vs_uir[u], vs_cdr[u], vs_sdr[u], vs_udr[u], jtag_state_rti[u], busy[u]};
   endfunction

   function automatic int divof(input int u);
      return (u == 0) ? 2 : 1;
   endfunction

   function automatic logic [37:0] capof(input int u);
      return (u == 0) ? cap0 : cap1;
   endfunction

   task automatic snapshot(input int u);
      for (int k = 0; k < 5; k++) begin
         rise_s[k] = rise_cnt[u][k];
         cyc_s[k]  = cyc_cnt[u][k];
      end
      tckr_s = tckr_cnt[u];
      tdih_s = tdih_cnt[u];
      viol_s = viol_cnt[u];
      rspr_s = rspr_cnt[u];
   endtask

   task automatic do_reset(input int cyc);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (cyc) @(posedge clk);
      #1;
      chk("reset_outs0", outs(0), 64'd0);
      chk("reset_outs1", outs(1), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset0", {63'd0, cmd_ready[0]}, 64'd1);
      chk("ready_after_reset1", {63'd0, cmd_ready[1]}, 64'd1);
      ir_loaded = '0;
      ir_model  = '0;
      irout_exp = '0;
   endtask

   task automatic send_cmd(input int u, input logic [1:0] ir, input logic [37:0] dr);
      int n;
      n = 0;
      while (cmd_ready[u] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready", {63'd0, cmd_ready[u]}, 64'd1);
      cmd_ir[u]    = ir;
      cmd_dr[u]    = dr;
      cmd_valid[u] = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid[u] = 1'b0;
   endtask

   task automatic run_txn(input int u, input logic [1:0] ir, input logic [37:0] dr,
                          input logic [37:0] pre, input logic [1:0] iro, input int hold);
      bit skip;
      int per, lat, bad, ncyc, nrise;
`ifdef NIOS2_SCAN_IR_SKIP_EN
      skip = ir_loaded[u] && (ir == ir_model[u]);
`else
      skip = 1'b0;
`endif
      per = 2 * divof(u);
      preload[u] = pre;
      ir_out[u]  = iro;
      snapshot(u);
      send_cmd(u, ir, dr);
      lat = 0;
      while (rsp_valid[u] !== 1'b1 && lat < 2000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'((42 - (skip ? 1 : 0)) * per));
      chk("rsp_dr", {26'd0, rsp_dr[u]}, {26'd0, pre});
      if (!skip) irout_exp[u] = iro;
      chk("rsp_ir_out", {62'd0, rsp_ir_out[u]}, {62'd0, irout_exp[u]});
      chk("ir_in", {62'd0, ir_in[u]}, {62'd0, ir});
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (rsp_dr[u] !== pre || rsp_valid[u] !== 1'b1 || cmd_ready[u] !== 1'b0 || tck[u] !== 1'b0)
            bad++;
      end
      if (hold > 0) chk("backpressure_hold", 64'(bad), 64'd0);
      rsp_ready[u] = 1'b1;
      cmd_valid[u] = 1'b1;  // must not be taken on the completing edge
      @(posedge clk);
      #1;
      rsp_ready[u] = 1'b0;
      cmd_valid[u] = 1'b0;
      chk("rsp_done", {61'd0, rsp_valid[u], busy[u], cmd_ready[u]}, 64'b001);
      chk("captured", {26'd0, capof(u)}, {26'd0, dr});
      for (int k = 0; k < 5; k++) begin
         nrise = (k == 4 && skip) ? 0 : 1;
         ncyc  = nrise * per * ((k == 2) ? 38 : 1);
         chk($sformatf("strobe%0d_rise", k), 64'(rise_cnt[u][k] - rise_s[k]), 64'(nrise));
         chk($sformatf("strobe%0d_cycles", k), 64'(cyc_cnt[u][k] - cyc_s[k]), 64'(ncyc));
      end
      chk("tck_periods", 64'(tckr_cnt[u] - tckr_s), 64'(42 - (skip ? 1 : 0)));
      chk("tdi_high_cycles", 64'(tdih_cnt[u] - tdih_s), 64'($countones(dr) * per));
      chk("protocol_viol", 64'(viol_cnt[u] - viol_s), 64'd0);
      chk("rsp_pulses", 64'(rspr_cnt[u] - rspr_s), 64'd1);
      ir_loaded[u] = 1'b1;
      ir_model[u]  = ir;
   endtask

   function automatic logic [37:0] rnd38();
      return {6'($urandom), 32'($urandom)};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rs;
      do_reset(3);

      // single directed transfer with defaults
      run_txn(0, 2'b01, 38'h2A_AAAA_AAAA, 38'h15_5555_5555, 2'b10, 0);

      // backpressure
      run_txn(0, 2'b11, rnd38(), rnd38(), 2'b01, 10);

      // reset mid-IDLE
      do_reset(3);

      // back-to-back commands with the same IR
      run_txn(0, 2'b10, rnd38(), rnd38(), 2'b11, 0);
      run_txn(0, 2'b10, rnd38(), rnd38(), 2'b00, 0);

      // abort in the middle of SDR
      preload[0] = rnd38();
      rs = rspr_cnt[0];
      send_cmd(0, 2'b01, rnd38());
      repeat ((2 + 20) * 4 + 2) @(posedge clk);
      #1;
      chk("abort_in_sdr", {63'd0, vs_sdr[0]}, 64'd1);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_state", {60'd0, vs_sdr[0], tck[0], busy[0], rsp_valid[0]}, 64'd0);
      do_reset(2);
      chk("abort_no_rsp", 64'(rspr_cnt[0] - rs), 64'd0);
      run_txn(0, 2'b01, rnd38(), rnd38(), 2'b01, 1);

      // TCK_DIV=1 instance
      run_txn(1, 2'b01, 38'h1, rnd38(), 2'b10, 0);
      run_txn(1, 2'b01, rnd38(), rnd38(), 2'b11, 2);

      // randomized traffic
      for (int i = 0; i < 6; i++)
         run_txn(0, 2'($urandom_range(2, 3)), rnd38(), rnd38(), 2'($urandom), $urandom_range(0, 3));
      for (int i = 0; i < 4; i++)
         run_txn(1, 2'($urandom_range(0, 1)), rnd38(), rnd38(), 2'($urandom), $urandom_range(0, 3));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
